// File: rtl/cop0_pkg.sv
// cop0_pkg: shared constants for the CP0 controller.
//   Register numbers, cop_op encodings, ExcCode values, STATUS bit
//   positions and the masks of software-writable STATUS/CAUSE fields.
package cop0_pkg;

    localparam logic [4:0] REG_COUNT     = 5'd9;
    localparam logic [4:0] REG_COMPARE   = 5'd11;
    localparam logic [4:0] REG_STATUS    = 5'd12;
    localparam logic [4:0] REG_CAUSE     = 5'd13;
    localparam logic [4:0] REG_EPC       = 5'd14;
    localparam logic [4:0] REG_ERROR_EPC = 5'd30;

    typedef enum logic [2:0] {
        COP_OP_NOP = 3'd0,
        COP_OP_MV  = 3'd1,
        COP_OP_EN  = 3'd2,
        COP_OP_DIS = 3'd3,
        COP_OP_RET = 3'd4,
        COP_OP_SYS = 3'd5,
        COP_OP_BRK = 3'd6
    } cop_op_e;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;

    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_ERL   = 2;
    localparam int unsigned ST_UM    = 4;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned ST_IM_HI = 15;
    localparam int unsigned ST_BEV   = 22;

    // STATUS: BEV(22), IM(15:8), UM(4), ERL(2), EXL(1), IE(0)
    localparam logic [31:0] STATUS_WR_MASK = 32'h0040_FF17;
    // CAUSE: software interrupt bits IP1:IP0 only
    localparam logic [31:0] CAUSE_WR_MASK  = 32'h0000_0300;

endpackage

// File: rtl/cop0_ctrl_if.sv
// cop0_ctrl_if: pipeline <-> CP0 bundle.
//   master: pipeline side (drives register access, ops, exceptions)
//   slave : CP0 side (returns rd_data, redirect, old_status, kernel_mode)
interface cop0_ctrl_if;
    logic [4:0]  reg_num;
    logic [2:0]  reg_sel;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [2:0]  cop_op;
    logic        op_valid;
    logic [31:0] op_pc;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] old_status;
    logic        kernel_mode;

    modport master (
        output reg_num, reg_sel, wr_en, wr_data, cop_op, op_valid, op_pc,
               exc_req, exc_code,
        input  rd_data, redirect_valid, redirect_pc, old_status, kernel_mode
    );

    modport slave (
        input  reg_num, reg_sel, wr_en, wr_data, cop_op, op_valid, op_pc,
               exc_req, exc_code,
        output rd_data, redirect_valid, redirect_pc, old_status, kernel_mode
    );
endinterface

// File: rtl/cop0_timer.sv
// cop0_timer: free-running COUNT, COMPARE and the sticky timer interrupt.
//   clk, rst_n            : clock, async active-low reset
//   wr_count, wr_compare  : mtc0 strobes for COUNT / COMPARE
//   wr_data               : mtc0 data
//   count, compare        : register values
//   ip7                   : timer interrupt pending (cleared by COMPARE write)
module cop0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ip7
);
    logic [31:0] count_inc;

    assign count_inc = count + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            compare <= '0;
            ip7     <= 1'b0;
        end else begin
            count <= wr_count ? wr_data : count_inc;
            if (wr_compare)
                compare <= wr_data;
            // Match is checked on the incremented value only; a COUNT write
            // overrides the increment and therefore cannot raise IP7.
            if (wr_compare)
                ip7 <= 1'b0;
            else if (!wr_count && count_inc == compare)
                ip7 <= 1'b1;
        end
    end
endmodule

// File: rtl/cop0_ctrl.sv
// cop0_ctrl: coprocessor-0 controller beside the execute stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : cop0_ctrl_if.slave (mfc0/mtc0, ops, exceptions, redirect)
//   hw_int     : level-sensitive external interrupts -> CAUSE.IP[2+:NUM_HW_INT]
// Optional: define COP0_TIMER_EN to build COUNT/COMPARE and the IP7 timer;
// otherwise COUNT/COMPARE read 0 and IP7 is 0.
module cop0_ctrl
    import cop0_pkg::*;
#(
    parameter int unsigned NUM_HW_INT   = 5,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_3000,
    parameter logic [31:0] BOOT_VECTOR  = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0004
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cop0_ctrl_if.slave            bus,
    input  logic [NUM_HW_INT-1:0] hw_int
);
    logic [31:0] status_q, epc_q, error_epc_q, cause;
    logic [1:0]  sw_ip_q;
    logic [4:0]  hw_ip_q, exc_code_q, entry_code;
    logic [31:0] count, compare;
    logic        ip7;
    logic        mtc0, int_take, op_ok, entry, take_ret, take_en, take_dis;
    logic [31:0] target;

`ifdef COP0_TIMER_EN
    cop0_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_count   (mtc0 && bus.reg_num == REG_COUNT),
        .wr_compare (mtc0 && bus.reg_num == REG_COMPARE),
        .wr_data    (bus.wr_data),
        .count      (count),
        .compare    (compare),
        .ip7        (ip7)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ip7     = 1'b0;
`endif

    assign cause = {16'd0, ip7, hw_ip_q, sw_ip_q, 1'b0, exc_code_q, 2'b00};
    assign bus.kernel_mode = ~status_q[ST_UM] | status_q[ST_EXL] | status_q[ST_ERL];

    always_comb begin
        int_take = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL] &
                   (|(cause[15:8] & status_q[ST_IM_HI:ST_IM_LO]));
        // exc_req and int_take both pre-empt whatever op sits in the stage.
        op_ok    = bus.op_valid & ~bus.exc_req & ~int_take;
        mtc0     = op_ok && bus.cop_op == COP_OP_MV && bus.wr_en && bus.reg_sel == 3'd0;
        take_ret = op_ok && bus.cop_op == COP_OP_RET;
        take_en  = op_ok && bus.cop_op == COP_OP_EN;
        take_dis = op_ok && bus.cop_op == COP_OP_DIS;
        entry    = bus.exc_req | int_take |
                   (op_ok && (bus.cop_op == COP_OP_SYS || bus.cop_op == COP_OP_BRK));
        if (bus.exc_req)                  entry_code = bus.exc_code;
        else if (int_take)                entry_code = EXC_INT;
        else if (bus.cop_op == COP_OP_SYS) entry_code = EXC_SYS;
        else                              entry_code = EXC_BP;
        if (take_ret)
            target = status_q[ST_ERL] ? error_epc_q : epc_q;
        else
            target = status_q[ST_BEV] ? BOOT_VECTOR : EXC_VECTOR;
    end

    always_comb begin
        bus.rd_data = '0;
        if (bus.reg_sel == 3'd0) begin
            case (bus.reg_num)
                REG_COUNT:     bus.rd_data = count;
                REG_COMPARE:   bus.rd_data = compare;
                REG_STATUS:    bus.rd_data = status_q;
                REG_CAUSE:     bus.rd_data = cause;
                REG_EPC:       bus.rd_data = epc_q;
                REG_ERROR_EPC: bus.rd_data = error_epc_q;
                default:       bus.rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q           <= STATUS_RESET;
            sw_ip_q            <= '0;
            hw_ip_q            <= '0;
            exc_code_q         <= '0;
            epc_q              <= '0;
            error_epc_q        <= '0;
            bus.old_status     <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
        end else begin
            hw_ip_q            <= 5'(hw_int);
            bus.redirect_valid <= entry | take_ret;
            if (entry | take_ret)
                bus.redirect_pc <= target;

            if (entry) begin
                if (!status_q[ST_EXL])
                    epc_q <= bus.op_pc;
                status_q[ST_EXL] <= 1'b1;
                exc_code_q       <= entry_code;
            end else if (take_ret) begin
                if (status_q[ST_ERL])
                    status_q[ST_ERL] <= 1'b0;
                else
                    status_q[ST_EXL] <= 1'b0;
            end else if (take_en | take_dis) begin
                bus.old_status  <= status_q;
                status_q[ST_IE] <= take_en;
            end else if (mtc0) begin
                case (bus.reg_num)
                    REG_STATUS:    status_q <= (status_q & ~STATUS_WR_MASK) |
                                               (bus.wr_data & STATUS_WR_MASK);
                    REG_CAUSE:     sw_ip_q <= bus.wr_data[9:8] & CAUSE_WR_MASK[9:8];
                    REG_EPC:       epc_q <= bus.wr_data;
                    REG_ERROR_EPC: error_epc_q <= bus.wr_data;
                    default:       ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cop0_ctrl.sv
// tb_cop0_ctrl: directed self-checking bench for cop0_ctrl.
//   Expected redirect targets are queued when an event is driven and popped
//   by a negedge monitor when redirect_valid pulses. Timer checks follow
//   COP0_TIMER_EN.
module tb_cop0_ctrl;
    import cop0_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] hw_int;

    cop0_ctrl_if bus ();

    cop0_ctrl #(
        .NUM_HW_INT   (5),
        .EXC_VECTOR   (32'h0000_3000),
        .BOOT_VECTOR  (32'hBFC0_0380),
        .STATUS_RESET (32'h0040_0004)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .hw_int (hw_int)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    int unsigned redir_cnt = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Redirect scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.redirect_valid === 1'b1) begin
            redir_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL redirect_unexpected: observed=%h expected=none", bus.redirect_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                assert (bus.redirect_pc === e) else begin
                    fails++;
                    $error("FAIL redirect_pc: observed=%h expected=%h", bus.redirect_pc, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd(input logic [4:0] r);
        bus.reg_num = r;
        bus.reg_sel = 3'd0;
        return dut.bus.rd_data;
    endfunction

    task automatic rdchk(input string tag, input logic [4:0] r, input logic [31:0] exp);
        bus.reg_num = r;
        bus.reg_sel = 3'd0;
        #1;
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.op_valid = 1'b1;
        bus.cop_op   = COP_OP_MV;
        bus.wr_en    = 1'b1;
        bus.reg_num  = r;
        bus.reg_sel  = 3'd0;
        bus.wr_data  = d;
        tick();
        bus.op_valid = 1'b0;
        bus.wr_en    = 1'b0;
        bus.cop_op   = COP_OP_NOP;
    endtask

    task automatic op(input logic [2:0] code, input logic [31:0] pc);
        bus.op_valid = 1'b1;
        bus.cop_op   = code;
        bus.op_pc    = pc;
        tick();
        bus.op_valid = 1'b0;
        bus.cop_op   = COP_OP_NOP;
    endtask

    task automatic wait_redirect(input string tag, input int unsigned n0);
        int unsigned k;
        k = 0;
        while (redir_cnt == n0 && k < 30) begin
            tick();
            k++;
        end
        chk(tag, 32'(redir_cnt - n0), 32'd1);
    endtask

    initial begin
        int unsigned n0;
        rst_n        = 1'b0;
        hw_int       = '0;
        bus.reg_num  = '0;
        bus.reg_sel  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.cop_op   = COP_OP_NOP;
        bus.op_valid = 1'b0;
        bus.op_pc    = '0;
        bus.exc_req  = 1'b0;
        bus.exc_code = '0;
        repeat (3) tick();

        chk("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_kernel_mode", {31'd0, bus.kernel_mode}, 32'd1);
        rdchk("rst_status", REG_STATUS, 32'h0040_0004);
        rdchk("rst_cause", REG_CAUSE, 32'd0);
        rdchk("rst_epc", REG_EPC, 32'd0);

        rst_n = 1'b1;
        repeat (3) tick();
`ifdef COP0_TIMER_EN
        rdchk("count_after_3", REG_COUNT, 32'd3);
`else
        rdchk("count_after_3", REG_COUNT, 32'd0);
`endif
        bus.reg_sel = 3'd1;
        bus.reg_num = REG_STATUS;
        #1;
        chk("rd_sel_nonzero", bus.rd_data, 32'd0);
        rdchk("rd_unimpl", 5'd5, 32'd0);

        // Read-only bit 28 must be ignored
        mtc0(REG_STATUS, 32'h1000_0401);
        rdchk("status_masked_wr", REG_STATUS, 32'h0000_0401);

        // Hardware interrupt entry
        bus.op_pc = 32'h100;
        hw_int    = 5'b00001;
        exp_q.push_back(32'h3000);
        n0 = redir_cnt;
        wait_redirect("int_redirect_seen", n0);
        rdchk("int_epc", REG_EPC, 32'h100);
        rdchk("int_status", REG_STATUS, 32'h0000_0403);
        hw_int = '0;
        tick();
        rdchk("int_cause_after_drop", REG_CAUSE, 32'd0);

        // SYS with EXL already set keeps EPC
        exp_q.push_back(32'h3000);
        op(COP_OP_SYS, 32'h180);
        rdchk("sys_nested_epc", REG_EPC, 32'h100);
        rdchk("sys_nested_cause", REG_CAUSE, 32'h20);
        exp_q.push_back(32'h100);
        op(COP_OP_RET, 32'h184);
        rdchk("ret1_status", REG_STATUS, 32'h0000_0401);

        exp_q.push_back(32'h3000);
        op(COP_OP_SYS, 32'h200);
        rdchk("sys_epc", REG_EPC, 32'h200);
        rdchk("sys_cause", REG_CAUSE, 32'h20);
        rdchk("sys_status", REG_STATUS, 32'h0000_0403);
        exp_q.push_back(32'h200);
        op(COP_OP_RET, 32'h3000);
        rdchk("ret2_status", REG_STATUS, 32'h0000_0401);

        mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        rdchk("cause_masked_wr", REG_CAUSE, 32'h320);
        mtc0(REG_CAUSE, 32'h0);
        mtc0(REG_EPC, 32'hDEAD_BEEF);
        rdchk("epc_wr", REG_EPC, 32'hDEAD_BEEF);
        mtc0(REG_ERROR_EPC, 32'h1234_5678);
        rdchk("error_epc_wr", REG_ERROR_EPC, 32'h1234_5678);

`ifdef COP0_TIMER_EN
        mtc0(REG_STATUS, 32'h0);
        mtc0(REG_COMPARE, 32'h0);
        mtc0(REG_COUNT, 32'hFFFF_FFFE);
        tick();
        tick();
        rdchk("count_wrap", REG_COUNT, 32'h0);
        rdchk("ip7_on_wrap", REG_CAUSE, 32'h8020);
        mtc0(REG_COMPARE, 32'd10);
        rdchk("ip7_clr_by_compare", REG_CAUSE, 32'h20);
        mtc0(REG_COUNT, 32'd5);
        rdchk("count_write_wins", REG_COUNT, 32'd5);
        bus.op_pc = 32'h300;
        exp_q.push_back(32'h3000);
        n0 = redir_cnt;
        mtc0(REG_STATUS, 32'h0000_8001);
        wait_redirect("timer_redirect_seen", n0);
        rdchk("timer_epc", REG_EPC, 32'h300);
        rdchk("timer_cause", REG_CAUSE, 32'h8000);
        mtc0(REG_COMPARE, 32'd100);
        rdchk("timer_ip7_clear", REG_CAUSE, 32'h0);
        mtc0(REG_COMPARE, 32'h0);
        exp_q.push_back(32'h300);
        op(COP_OP_RET, 32'h3000);
        rdchk("timer_ret_status", REG_STATUS, 32'h0000_8001);
`else
        mtc0(REG_COUNT, 32'd5);
        rdchk("count_ignored", REG_COUNT, 32'd0);
        mtc0(REG_COMPARE, 32'd10);
        rdchk("compare_ignored", REG_COMPARE, 32'd0);
        rdchk("no_ip7", REG_CAUSE, 32'h20);
`endif

        // ei / di
        mtc0(REG_STATUS, 32'h0000_0401);
        op(COP_OP_DIS, 32'h280);
        chk("di_old_status", bus.old_status, 32'h0000_0401);
        rdchk("di_status", REG_STATUS, 32'h0000_0400);
        op(COP_OP_EN, 32'h284);
        chk("ei_old_status", bus.old_status, 32'h0000_0400);
        rdchk("ei_status", REG_STATUS, 32'h0000_0401);

        // exc_req beats a pending interrupt and a BRK in the same cycle
        hw_int = 5'b00001;
        tick();
        bus.exc_req  = 1'b1;
        bus.exc_code = 5'd12;
        exp_q.push_back(32'h3000);
        n0 = redir_cnt;
        op(COP_OP_BRK, 32'h400);
        bus.exc_req = 1'b0;
        hw_int      = '0;
        repeat (3) tick();
        chk("prio_one_pulse", 32'(redir_cnt - n0), 32'd1);
        rdchk("prio_cause", REG_CAUSE, 32'h30);
        rdchk("prio_epc", REG_EPC, 32'h400);
        exp_q.push_back(32'h400);
        op(COP_OP_RET, 32'h3000);

        // BRK, then reset while the redirect pulse is high
        exp_q.push_back(32'h3000);
        op(COP_OP_BRK, 32'h500);
        chk("brk_pulse_high", {31'd0, bus.redirect_valid}, 32'd1);
        rdchk("brk_cause", REG_CAUSE, 32'h24);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_mid_pc", bus.redirect_pc, 32'd0);
        rdchk("rst_mid_status", REG_STATUS, 32'h0040_0004);
        rdchk("rst_mid_epc", REG_EPC, 32'd0);
        rdchk("rst_mid_error_epc", REG_ERROR_EPC, 32'd0);
        rdchk("rst_mid_count", REG_COUNT, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ERL return uses ERROR_EPC; BEV=1 selects the boot vector
        mtc0(REG_ERROR_EPC, 32'h600);
        exp_q.push_back(32'h600);
        op(COP_OP_RET, 32'h0);
        rdchk("erl_ret_status", REG_STATUS, 32'h0040_0000);
        exp_q.push_back(32'hBFC0_0380);
        op(COP_OP_SYS, 32'h700);
        rdchk("bev_epc", REG_EPC, 32'h700);
        rdchk("bev_status", REG_STATUS, 32'h0040_0002);

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
